// File: rtl/i2c_temp_reader.sv
// I2C master that reads the ADT7420 temperature register (pointer 0x00) and reduces the
// 16-bit result to an integer-degree byte for the host.
module i2c_temp_reader #(
  parameter int unsigned CLK_HZ   = 200_000_000,
  parameter int unsigned SCL_HZ   = 100_000,
  parameter logic [6:0]  DEV_ADDR = 7'h4B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_i,
  output logic        busy,
  output logic        valid,
  output logic        ack_err,
  output logic [15:0] temp_raw,
  output logic [7:0]  temp
);

  localparam int unsigned QTR = CLK_HZ / (4 * SCL_HZ);
  localparam int unsigned QW  = (QTR > 1) ? $clog2(QTR) : 1;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StWaddr,
    StAck1,
    StPtr,
    StAck2,
    StRstart,
    StRaddr,
    StAck3,
    StRdMsb,
    StMack,
    StRdLsb,
    StMnack,
    StStop
  } state_e;

  state_e        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    msb_q, msb_d;
  logic          ack_err_q, ack_err_d;
  logic [15:0]   temp_raw_q, temp_raw_d;
  logic [7:0]    temp_q, temp_d;
  logic          valid_q, valid_d;
  logic          scl_oe_q, scl_d;
  logic          sda_oe_q, sda_d;

  logic          tick;
  logic          byte_state;
  logic          scl_low_phase;
  logic [7:0]    tx_byte;

  assign tick          = (qcnt_q == QW'(QTR - 1));
  assign byte_state    = state_q inside {StWaddr, StPtr, StRaddr, StRdMsb, StRdLsb};
  // Ordinary bits hold SCL low in q3 and q0, released in q1 and q2.
  assign scl_low_phase = (phase_q == 2'd0) || (phase_q == 2'd3);

  always_comb begin
    state_d    = state_q;
    qcnt_d     = qcnt_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    rx_d       = rx_q;
    msb_d      = msb_q;
    ack_err_d  = ack_err_q;
    temp_raw_d = temp_raw_q;
    temp_d     = temp_q;
    valid_d    = 1'b0;

    if (state_q == StIdle) begin
      qcnt_d  = '0;
      phase_d = 2'd0;
      bit_d   = 3'd7;
      if (start) begin
        state_d   = StStart;
        ack_err_d = 1'b0;
      end
    end else if (!tick) begin
      qcnt_d = qcnt_q + QW'(1);
    end else begin
      qcnt_d  = '0;
      phase_d = phase_q + 2'd1;

      if (phase_q == 2'd2) begin
        if (state_q inside {StRdMsb, StRdLsb}) begin
          rx_d = {rx_q[6:0], sda_i};
        end
        if ((state_q inside {StAck1, StAck2, StAck3}) && sda_i) begin
          ack_err_d = 1'b1;
        end
      end

      if (phase_q == 2'd3) begin
        // Wraps 0 -> 7 so the next byte state starts at its MSB.
        if (byte_state) begin
          bit_d = bit_q - 3'd1;
        end
        case (state_q)
          StStart:  state_d = StWaddr;
          StWaddr:  if (bit_q == 3'd0) state_d = StAck1;
          StAck1:   state_d = ack_err_q ? StStop : StPtr;
          StPtr:    if (bit_q == 3'd0) state_d = StAck2;
          StAck2:   state_d = ack_err_q ? StStop : StRstart;
          StRstart: state_d = StRaddr;
          StRaddr:  if (bit_q == 3'd0) state_d = StAck3;
          StAck3:   state_d = ack_err_q ? StStop : StRdMsb;
          StRdMsb: begin
            if (bit_q == 3'd0) begin
              state_d = StMack;
              msb_d   = rx_q;
            end
          end
          StMack:   state_d = StRdLsb;
          StRdLsb:  if (bit_q == 3'd0) state_d = StMnack;
          StMnack:  state_d = StStop;
          StStop: begin
            state_d = StIdle;
            if (!ack_err_q) begin
              temp_raw_d = {msb_q, rx_q};
              temp_d     = msb_q[7] ? 8'h00 : {msb_q[6:0], rx_q[7]};
              valid_d    = 1'b1;
            end
          end
          default:  state_d = StIdle;
        endcase
      end
    end
  end

  always_comb begin
    scl_d = 1'b0;
    sda_d = 1'b0;
    case (state_q)
      StWaddr: tx_byte = {DEV_ADDR, 1'b0};
      StRaddr: tx_byte = {DEV_ADDR, 1'b1};
      default: tx_byte = 8'h00;
    endcase
    case (state_q)
      StIdle: begin
        scl_d = 1'b0;
        sda_d = 1'b0;
      end
      // SCL is already high from idle: SDA falls at q1, SCL follows at q3.
      StStart: begin
        scl_d = (phase_q == 2'd3);
        sda_d = (phase_q != 2'd0);
      end
      // SCL low with SDA released, then high; SDA falls at q2 while SCL is high.
      StRstart: begin
        scl_d = scl_low_phase;
        sda_d = phase_q[1];
      end
      // SDA held low while SCL rises at q1, released at q2 with SCL high.
      StStop: begin
        scl_d = (phase_q == 2'd0);
        sda_d = !phase_q[1];
      end
      StWaddr, StPtr, StRaddr: begin
        scl_d = scl_low_phase;
        sda_d = !tx_byte[bit_q];
      end
      StMack: begin
        scl_d = scl_low_phase;
        sda_d = 1'b1;
      end
      default: begin
        scl_d = scl_low_phase;
        sda_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      qcnt_q     <= '0;
      phase_q    <= 2'd0;
      bit_q      <= 3'd7;
      rx_q       <= 8'h00;
      msb_q      <= 8'h00;
      ack_err_q  <= 1'b0;
      temp_raw_q <= 16'h0000;
      temp_q     <= 8'h00;
      valid_q    <= 1'b0;
      scl_oe_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      qcnt_q     <= qcnt_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      rx_q       <= rx_d;
      msb_q      <= msb_d;
      ack_err_q  <= ack_err_d;
      temp_raw_q <= temp_raw_d;
      temp_q     <= temp_d;
      valid_q    <= valid_d;
      // Registered pad drives keep SCL/SDA glitch-free; the one-cycle lag applies equally.
      scl_oe_q   <= scl_d;
      sda_oe_q   <= sda_d;
    end
  end

  assign scl_oe   = scl_oe_q;
  assign sda_oe   = sda_oe_q;
  assign busy     = (state_q != StIdle);
  assign valid    = valid_q;
  assign ack_err  = ack_err_q;
  assign temp_raw = temp_raw_q;
  assign temp     = temp_q;

endmodule

// File: tb/tb_i2c_temp_reader.sv
// Bench for i2c_temp_reader: behavioural ADT7420-style slave on a pulled-up open-drain bus,
// directed read / NACK / busy-restart / mid-read reset scenarios.
`timescale 1ns/1ps
module tb_i2c_temp_reader;

  localparam int unsigned CLK_HZ = 8_000_000;
  localparam int unsigned SCL_HZ = 1_000_000;
  localparam int          QTR    = 2;
  localparam int          LIMIT  = 3000;

  localparam int MIdle = 0;
  localparam int MRx   = 1;
  localparam int MAck  = 2;
  localparam int MTx   = 3;
  localparam int MMack = 4;

  typedef int frame_t [6];

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        scl_oe, sda_oe, busy, valid, ack_err;
  logic [15:0] temp_raw;
  logic [7:0]  temp;
  logic        scl_bus, sda_bus;
  logic        slv_oe = 1'b0;

  assign scl_bus = !(scl_oe === 1'b1);
  assign sda_bus = !((sda_oe === 1'b1) || slv_oe);

  i2c_temp_reader #(
    .CLK_HZ  (CLK_HZ),
    .SCL_HZ  (SCL_HZ),
    .DEV_ADDR(7'h4B)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .scl_oe  (scl_oe),
    .sda_oe  (sda_oe),
    .sda_i   (sda_bus),
    .busy    (busy),
    .valid   (valid),
    .ack_err (ack_err),
    .temp_raw(temp_raw),
    .temp    (temp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Slave model: logs START (-1), STOP (-2) and every byte the master writes.
  int         ev_q[$];
  int         mode = MIdle;
  int         bcnt = 0;
  int         bidx = 0;
  int         rd_idx = 0;
  logic [7:0] sh = 8'h00;
  logic       rd_bit = 1'b0;
  logic       nack_now = 1'b0;
  logic       nack_addr = 1'b0;
  logic       mack_seen = 1'b1;
  logic [7:0] rd_data [2];

  always @(negedge sda_bus) begin
    if (scl_bus === 1'b1 && rst_n === 1'b1) begin
      ev_q.push_back(-1);
      mode = MRx;
      bcnt = 0;
      bidx = 0;
    end
  end

  always @(posedge sda_bus) begin
    if (scl_bus === 1'b1 && rst_n === 1'b1) begin
      ev_q.push_back(-2);
      mode   = MIdle;
      slv_oe = 1'b0;
    end
  end

  always @(negedge rst_n) begin
    mode   = MIdle;
    slv_oe = 1'b0;
    bcnt   = 0;
  end

  always @(posedge scl_bus) begin
    if (rst_n === 1'b1) begin
      if (mode == MRx) begin
        sh = {sh[6:0], sda_bus};
        bcnt++;
        if (bcnt == 8) ev_q.push_back(int'(sh));
      end else if (mode == MMack) begin
        mack_seen = sda_bus;
      end
    end
  end

  always @(negedge scl_bus) begin
    if (rst_n === 1'b1) begin
      if (mode == MRx && bcnt == 8) begin
        nack_now = (bidx == 0) && nack_addr;
        slv_oe   = !nack_now;
        if (bidx == 0) rd_bit = sh[0];
        mode = MAck;
      end else if (mode == MAck) begin
        slv_oe = 1'b0;
        if (nack_now) begin
          mode = MIdle;
        end else if (bidx == 0 && rd_bit) begin
          mode   = MTx;
          rd_idx = 0;
          bcnt   = 0;
          slv_oe = !rd_data[0][7];
        end else begin
          mode = MRx;
          bcnt = 0;
        end
        bidx++;
      end else if (mode == MTx) begin
        bcnt++;
        if (bcnt == 8) begin
          slv_oe = 1'b0;
          mode   = MMack;
        end else begin
          slv_oe = !rd_data[rd_idx][7-bcnt];
        end
      end else if (mode == MMack) begin
        if (!mack_seen && rd_idx == 0) begin
          rd_idx = 1;
          bcnt   = 0;
          mode   = MTx;
          slv_oe = !rd_data[1][7];
        end else begin
          slv_oe = 1'b0;
          mode   = MIdle;
        end
      end
    end
  end

  int valid_cnt = 0;
  always @(negedge clk) if (valid === 1'b1) valid_cnt++;

  // SCL high/low run lengths in clk cycles.
  int   run_len = 0;
  logic scl_prev = 1'b1;
  int   min_hi = 1 << 30;
  int   min_lo = 1 << 30;
  bit   meas_en = 1'b0;
  always @(negedge clk) begin
    if (scl_bus != scl_prev) begin
      if (meas_en && run_len > 0) begin
        if (scl_prev) min_hi = (run_len < min_hi) ? run_len : min_hi;
        else          min_lo = (run_len < min_lo) ? run_len : min_lo;
      end
      scl_prev = scl_bus;
      run_len  = 1;
    end else begin
      run_len++;
    end
  end

  task automatic check_frame(input string tag, input frame_t exp, input int n);
    check_eq({tag, "_len"}, ev_q.size(), n);
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_ev%0d", tag, i), (i < ev_q.size()) ? ev_q[i] : 999, exp[i]);
    end
  endtask

  task automatic run_txn(input bit hold, output logic busy_a, output logic ack_a,
                         output logic valid_f, output int cyc);
    ev_q.delete();
    valid_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    busy_a = busy;
    ack_a  = ack_err;
    cyc    = 0;
    while (busy === 1'b1 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    valid_f = valid;
    start   = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic   b_a, a_a, v_f;
    int     cyc;
    frame_t f_good;
    frame_t f_nack;
    f_good = '{-1, 32'h96, 32'h00, -1, 32'h97, -2};
    f_nack = '{-1, 32'h96, -2, 0, 0, 0};

    repeat (3) @(negedge clk);
    check_eq("rst_scl_oe",   scl_oe,   0);
    check_eq("rst_sda_oe",   sda_oe,   0);
    check_eq("rst_busy",     busy,     0);
    check_eq("rst_valid",    valid,    0);
    check_eq("rst_ack_err",  ack_err,  0);
    check_eq("rst_temp_raw", temp_raw, 0);
    check_eq("rst_temp",     temp,     0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Good read, +25 C.
    meas_en    = 1'b1;
    nack_addr  = 1'b0;
    rd_data[0] = 8'h0C;
    rd_data[1] = 8'h80;
    run_txn(1'b0, b_a, a_a, v_f, cyc);
    check_eq("a_busy_after_start", b_a, 1);
    check_eq("a_timeout",     cyc < LIMIT, 1);
    check_eq("a_valid_at_busy_fall", v_f, 1);
    check_eq("a_valid_count", valid_cnt, 1);
    check_eq("a_temp_raw",    temp_raw, 32'h0C80);
    check_eq("a_temp",        temp, 25);
    check_eq("a_ack_err",     ack_err, 0);
    check_frame("a_frame", f_good, 6);

    // Address NACK: STOP after ACK1, outputs hold.
    nack_addr = 1'b1;
    run_txn(1'b0, b_a, a_a, v_f, cyc);
    check_eq("b_busy_after_start", b_a, 1);
    check_eq("b_timeout",     cyc < LIMIT, 1);
    check_eq("b_valid_count", valid_cnt, 0);
    check_eq("b_ack_err",     ack_err, 1);
    check_eq("b_temp_hold",   temp, 25);
    check_eq("b_temp_raw_hold", temp_raw, 32'h0C80);
    check_frame("b_frame", f_nack, 3);

    // Negative reading clamps to 0; new start clears ack_err.
    nack_addr  = 1'b0;
    rd_data[0] = 8'hF3;
    rd_data[1] = 8'h80;
    run_txn(1'b0, b_a, a_a, v_f, cyc);
    check_eq("c_ack_err_cleared", a_a, 0);
    check_eq("c_timeout",     cyc < LIMIT, 1);
    check_eq("c_valid_count", valid_cnt, 1);
    check_eq("c_temp_raw",    temp_raw, 32'hF380);
    check_eq("c_temp",        temp, 0);
    check_eq("c_ack_err",     ack_err, 0);
    check_frame("c_frame", f_good, 6);

    // start held high through busy, including the edge where busy falls.
    rd_data[0] = 8'h0C;
    rd_data[1] = 8'h80;
    run_txn(1'b1, b_a, a_a, v_f, cyc);
    check_eq("d_timeout",     cyc < LIMIT, 1);
    check_eq("d_valid_count", valid_cnt, 1);
    check_eq("d_busy_stays_low", busy, 0);
    check_eq("d_temp",        temp, 25);
    check_frame("d_frame", f_good, 6);

    meas_en = 1'b0;
    check_eq("scl_high_min_ok", min_hi >= 2 * QTR, 1);
    check_eq("scl_low_min_ok",  min_lo >= 2 * QTR, 1);

    // Reset while the sensor is returning the MSB.
    ev_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (!(mode == MTx && rd_idx == 0 && bcnt == 3) && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("e_reach_rd_msb", cyc < LIMIT, 1);
    check_eq("e_busy_before",  busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("e_scl_oe", scl_oe, 0);
    check_eq("e_sda_oe", sda_oe, 0);
    check_eq("e_busy",   busy,   0);
    check_eq("e_temp",   temp,   0);
    check_eq("e_valid",  valid,  0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Recovery after the abort.
    run_txn(1'b0, b_a, a_a, v_f, cyc);
    check_eq("f_timeout",     cyc < LIMIT, 1);
    check_eq("f_valid_count", valid_cnt, 1);
    check_eq("f_temp_raw",    temp_raw, 32'h0C80);
    check_eq("f_temp",        temp, 25);
    check_frame("f_frame", f_good, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
